// File: rtl/cex_enumerator_if.sv
// Handshake bundle between the counterexample enumerator, the combinational
// error-formula checker and the Skolem-repair consumer.
// slave  : the enumerator side (drives the assignment, status and FIFO head)
// master : the environment side (drives start, checker result and cex_ready)
interface cex_enumerator_if #(
  parameter int W = 5
);
  logic         start;
  logic [W-1:0] assign_out;
  logic         err_in;
  logic         busy;
  logic         done;
  logic         sat;
  logic [W:0]   cex_count;
  logic         cex_valid;
  logic [W-1:0] cex_data;
  logic         cex_ready;

  modport slave (
    input  start, err_in, cex_ready,
    output assign_out, busy, done, sat, cex_count, cex_valid, cex_data
  );

  modport master (
    output start, err_in, cex_ready,
    input  assign_out, busy, done, sat, cex_count, cex_valid, cex_data
  );
endinterface

// File: rtl/cex_enumerator.sv
// Exhaustive counterexample search engine.
// Walks every assignment {X, Y, Y'} in ascending order, samples the checker's
// same-cycle error bit and buffers failing assignments in a small FIFO that is
// drained over a valid/ready port.
// Optional build macro: CEX_EARLY_STOP_EN -- stop the scan at the first
// counterexample pushed (one counterexample per repair iteration).
//
// state | meaning
// IDLE  | waiting for start after reset
// SCAN  | presenting counter on assign_out, evaluating err_in each edge
// STALL | error seen with FIFO full; counter held until a slot frees up
// DONE  | all assignments evaluated (or early stop); waiting for restart
module cex_enumerator #(
  parameter int NX         = 1,
  parameter int NY         = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  cex_enumerator_if.slave  bus
);
  localparam int W  = NX + 2 * NY;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [W-1:0] LAST      = {W{1'b1}};
  localparam logic [AW:0]  DEPTH_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  counter;
  logic [W:0]    cex_count;
  logic          busy;
  logic          done;
  logic          sat;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Full is the registered occupancy, so a pop in the same cycle does not
  // free a slot for the push; the STALL round trip absorbs that case.
  always_comb begin
    full  = (fifo_count == DEPTH_CNT);
    empty = (fifo_count == '0);
    push  = (state == SCAN) && bus.err_in && !full;
    pop   = !empty && bus.cex_ready;
  end

  // Counterexample buffer: ascending-order storage, pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= counter;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Scan sequencer with registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      cex_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SCAN;
            counter <= '0;
            busy    <= 1'b1;
          end
        end

        SCAN: begin
          if (bus.err_in && full) begin
            // Hold the assignment; it is re-evaluated once a slot frees up.
            state <= STALL;
          end else begin
            if (push) begin
              cex_count <= cex_count + 1'b1;
              sat       <= 1'b1;
            end
`ifdef CEX_EARLY_STOP_EN
            if (push || counter == LAST) begin
`else
            if (counter == LAST) begin
`endif
              // The counter never wraps into a second pass.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end

        STALL: begin
          if (!full) begin
            state <= SCAN;
          end
        end

        DONE: begin
          if (bus.start) begin
            // Restart keeps buffered counterexamples for the consumer.
            state     <= SCAN;
            counter   <= '0;
            cex_count <= '0;
            sat       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.assign_out = counter;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.sat        = sat;
  assign bus.cex_count  = cex_count;
  assign bus.cex_valid  = !empty;
  assign bus.cex_data   = mem[rd_ptr];

endmodule

// File: tb/tb_cex_enumerator.sv
// Bench for cex_enumerator: reset checks, a table of fixed error maps,
// hand-written stall / restart / reset sequences, and randomized error maps
// with random consumer backpressure checked against a set-based model
// (the counterexamples are exactly the failing assignments, in ascending order).
module tb_cex_enumerator;
  localparam int NX    = 1;
  localparam int NY    = 2;
  localparam int W     = NX + 2 * NY;
  localparam int N     = 1 << W;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cex_enumerator_if #(.W(W)) bus ();

  cex_enumerator #(.NX(NX), .NY(NY), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Checker: real error formula or a stub lookup of failing assignments.
  logic         use_real;
  logic [N-1:0] err_map;

  function automatic logic real_checker(input logic [W-1:0] a);
    logic x, y1, y2, yp1, yp2, f, fp, sk;
    {x, y1, y2, yp1, yp2} = a;
    f  = (y2 == ~x) || (y1 && y2);
    fp = (yp2 == ~x) || (yp1 && yp2);
    sk = (yp1 == 1'b0) && (yp2 == ~x);
    return f & sk & ~fp;
  endfunction

  assign bus.err_in = use_real ? real_checker(bus.assign_out) : err_map[bus.assign_out];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [W-1:0] got[$];
  logic [W-1:0] exp_q[$];
  int           scan_cycles;
  logic         saw_valid;

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    bus.cex_ready = 1'b1;
    while (bus.cex_valid && guard < 16) begin
      got.push_back(bus.cex_data);
      @(negedge clk);
      guard++;
    end
    bus.cex_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    while (!bus.done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_timeout"}, guard < 2000, 1);
  endtask

  // mode 0: consumer always ready; 1: random ready; 2: never ready during scan
  task automatic run_scan(input logic [N-1:0] map, input int mode);
    int guard = 0;
    err_map     = map;
    scan_cycles = 0;
    saw_valid   = 1'b0;
    got.delete();
    pulse_start();
    while (!bus.done && guard < 2000) begin
      if (bus.busy) scan_cycles++;
      if (bus.cex_valid) saw_valid = 1'b1;
      bus.cex_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus.cex_valid && bus.cex_ready) got.push_back(bus.cex_data);
      @(negedge clk);
      guard++;
    end
    check("scan_timeout", guard < 2000, 1);
    drain();
  endtask

  // Model: the failing set in ascending order (only the first under early stop).
  task automatic score(input string tag, input logic [N-1:0] map);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (map[i]) exp_q.push_back(W'(i));
    end
`ifdef CEX_EARLY_STOP_EN
    while (exp_q.size() > 1) void'(exp_q.pop_back());
`endif
    check({tag, "_count"}, bus.cex_count, exp_q.size());
    check({tag, "_sat"}, bus.sat, exp_q.size() != 0);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ncex"}, got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      check({tag, "_data"}, got[k], exp_q[k]);
    end
  endtask

  typedef struct {
    logic [N-1:0] map;
    int           mode;
    int           exp_count;
    int           exp_first;
    int           exp_cycles;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    int exp_cyc;
    int guard;

    vecs[0] = '{map: 32'h0000_0000, mode: 0, exp_count: 0,  exp_first: 0,  exp_cycles: 32};
    vecs[1] = '{map: 32'h0002_0008, mode: 0, exp_count: 2,  exp_first: 3,  exp_cycles: 32};
    vecs[2] = '{map: 32'h8000_0000, mode: 0, exp_count: 1,  exp_first: 31, exp_cycles: 32};
    vecs[3] = '{map: 32'h0000_0001, mode: 0, exp_count: 1,  exp_first: 0,  exp_cycles: 32};
    vecs[4] = '{map: 32'hFFFF_FFFF, mode: 0, exp_count: 32, exp_first: 0,  exp_cycles: 32};
    vecs[5] = '{map: 32'h0000_00F0, mode: 2, exp_count: 4,  exp_first: 4,  exp_cycles: 32};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cex_ready = 1'b0;
    use_real      = 1'b0;
    err_map       = '0;

    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_count", bus.cex_count, 0);
    check("rst_valid", bus.cex_valid, 0);
    check("rst_assign", bus.assign_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Real checker with valid Skolem functions: no counterexample anywhere.
    use_real = 1'b1;
    run_scan('0, 0);
    check("real_cycles", scan_cycles, 32);
    check("real_done", bus.done, 1);
    check("real_sat", bus.sat, 0);
    check("real_count", bus.cex_count, 0);
    check("real_never_valid", saw_valid, 0);
    use_real = 1'b0;

    // Fixed error maps.
    for (int v = 0; v < 6; v++) begin
`ifdef CEX_EARLY_STOP_EN
      exp_cnt = (vecs[v].exp_count > 0) ? 1 : 0;
      exp_cyc = (vecs[v].exp_count > 0) ? vecs[v].exp_first + 1 : 32;
`else
      exp_cnt = vecs[v].exp_count;
      exp_cyc = vecs[v].exp_cycles;
`endif
      run_scan(vecs[v].map, vecs[v].mode);
      check("tbl_count", bus.cex_count, exp_cnt);
      check("tbl_cycles", scan_cycles, exp_cyc);
      if (exp_cnt > 0) check("tbl_first", got.size() > 0 ? got[0] : 'x, vecs[v].exp_first);
      score("tbl", vecs[v].map);
    end

`ifndef CEX_EARLY_STOP_EN
    // Error everywhere, consumer stalled: 4 pushes then STALL at 4.
    err_map = '1;
    pulse_start();
    repeat (8) @(negedge clk);
    check("stall_assign", bus.assign_out, 4);
    check("stall_busy", bus.busy, 1);
    check("stall_count", bus.cex_count, 4);
    check("stall_head", bus.cex_data, 0);
    check("stall_done", bus.done, 0);
    bus.cex_ready = 1'b1;
    @(negedge clk);
    bus.cex_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("stall2_assign", bus.assign_out, 5);
    check("stall2_count", bus.cex_count, 5);
    check("stall2_head", bus.cex_data, 1);
    check("stall2_busy", bus.busy, 1);
    // start while busy is ignored
    pulse_start();
    @(negedge clk);
    check("busy_start_assign", bus.assign_out, 5);
    check("busy_start_count", bus.cex_count, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-scan at counter 10 with two buffered entries.
    err_map = 32'h0000_0044;
    pulse_start();
    guard = 0;
    while (bus.assign_out != 10 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_reach10", guard < 100, 1);
    check("midrst_fifo2", bus.cex_count, 2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", bus.cex_valid, 0);
    check("midrst_count", bus.cex_count, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_assign", bus.assign_out, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", bus.busy, 0);

    // Restart from DONE: counters cleared, FIFO contents kept.
    err_map = 32'h0002_0008;
    pulse_start();
    wait_done("rescan1");
    check("rescan1_count", bus.cex_count, 2);
    err_map = 32'h0000_0020;
    pulse_start();
    check("rescan_done", bus.done, 0);
    check("rescan_busy", bus.busy, 1);
    check("rescan_count", bus.cex_count, 0);
    check("rescan_sat", bus.sat, 0);
    check("rescan_assign", bus.assign_out, 0);
    check("rescan_head", bus.cex_data, 3);
    wait_done("rescan2");
    check("rescan2_count", bus.cex_count, 1);
    got.delete();
    drain();
    check("rescan_n", got.size(), 3);
    if (got.size() == 3) begin
      check("rescan_d0", got[0], 5'h03);
      check("rescan_d1", got[1], 5'h11);
      check("rescan_d2", got[2], 5'h05);
    end
`else
    // Early stop at 5'h07.
    run_scan(32'h0000_0080, 0);
    check("early_cycles", scan_cycles, 8);
    check("early_count", bus.cex_count, 1);
    check("early_n", got.size(), 1);
    if (got.size() > 0) check("early_data", got[0], 5'h07);
`endif

    // Randomized error maps with random backpressure.
    for (int r = 0; r < 24; r++) begin
      logic [N-1:0] m;
      m = (r % 3 == 0) ? N'($urandom) : N'($urandom & $urandom);
      run_scan(m, 1);
`ifndef CEX_EARLY_STOP_EN
      check("rnd_cycles_min", scan_cycles >= N, 1);
`endif
      score("rnd", m);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
